// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF_ID pipeline register feeding the decoder.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              ifid_valid,
  output logic [INST_W-1:0] ifid_inst,
  output logic [PC_W-1:0]   ifid_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   req_pc;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   redirect_aligned;
  logic              accept;
  logic              load_rsp;
  logic              load_skid;
  logic              fill_skid;

  assign imem_req_addr    = pc;
  assign redirect_aligned = redirect_pc & ~PC_W'(3);
  assign accept           = (state == REQ) && imem_req_ready;
  assign load_rsp         = (state == WAIT) && imem_rsp_valid && !stall && !redirect_valid;
  assign fill_skid        = (state == WAIT) && imem_rsp_valid && stall && !redirect_valid;
  assign load_skid        = (state == HOLD) && !stall && !redirect_valid;

  // A redirect turns any request already accepted for the old pc into one
  // that must be drained in DROP; a response in DROP always ends the drain.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (accept) state_next = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid)  state_next = REQ;
          else if (stall)      state_next = HOLD;
          else                 state_next = REQ;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) state_next = REQ;
      end
      DROP: begin
        if (imem_rsp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      imem_req_valid <= 1'b0;
      pc             <= RESET_PC;
      req_pc         <= '0;
      skid_pc        <= '0;
      skid_inst      <= NOP;
      ifid_valid     <= 1'b0;
      ifid_inst      <= NOP;
      ifid_pc        <= '0;
    end else begin
      state          <= state_next;
      imem_req_valid <= (state_next == REQ);

      if (accept) req_pc <= pc;

      if (redirect_valid) pc <= redirect_aligned;
      else if (accept)    pc <= pc + PC_W'(4);

      if (fill_skid) begin
        skid_inst <= imem_rsp_data;
        skid_pc   <= req_pc;
      end

      // Redirect squashes IF_ID even under stall; otherwise stall freezes it
      // and an idle cycle inserts a bubble.
      if (redirect_valid) begin
        ifid_valid <= 1'b0;
        ifid_inst  <= NOP;
      end else if (load_rsp) begin
        ifid_valid <= 1'b1;
        ifid_inst  <= imem_rsp_data;
        ifid_pc    <= req_pc;
      end else if (load_skid) begin
        ifid_valid <= 1'b1;
        ifid_inst  <= skid_inst;
        ifid_pc    <= skid_pc;
      end else if (!stall) begin
        ifid_valid <= 1'b0;
        ifid_inst  <= NOP;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_rsp || load_skid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && ifid_valid)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed opening scenarios, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        req_valid, ifid_valid;
  logic [31:0] req_addr, ifid_inst, ifid_pc;
  logic        w_req_valid, w_ifid_valid;
  logic [31:0] w_req_addr, w_ifid_inst, w_ifid_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
  logic [31:0] m_fetch, m_stallc;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: pending request, skid entry, IF_ID contents.
  logic        m_started, m_out, m_out_drop, m_skid, m_ifid_v;
  logic [31:0] m_pc, m_out_pc, m_skid_pc, m_ifid_inst, m_ifid_pc;

  // Memory: a single outstanding access answered after a chosen latency.
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  logic [31:0] acc_q[$];
  logic [31:0] wrap_q[$];
  logic [31:0] obs_pc_q[$];
  logic [31:0] obs_inst_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch), .perf_stall_cnt(perf_stall)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(w_ifid_valid), .ifid_inst(w_ifid_inst), .ifid_pc(w_ifid_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a | 32'h13;
  endfunction

  task automatic cmp(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input int cyc);
    logic exp_req;
    exp_req = m_started && !m_out && !m_skid;
    cmp("req_valid", cyc, 32'(req_valid), 32'(exp_req));
    if (exp_req) cmp("req_addr", cyc, req_addr, m_pc);
    cmp("ifid_valid", cyc, 32'(ifid_valid), 32'(m_ifid_v));
    cmp("ifid_inst", cyc, ifid_inst, m_ifid_inst);
    if (m_ifid_v) cmp("ifid_pc", cyc, ifid_pc, m_ifid_pc);
    // The wrap instance tracks the main one 4 bytes lower until a redirect.
    if (cyc <= 13) begin
      cmp("wrap_req_valid", cyc, 32'(w_req_valid), 32'(exp_req));
      if (exp_req) cmp("wrap_req_addr", cyc, w_req_addr, m_pc - 32'd4);
      cmp("wrap_ifid_valid", cyc, 32'(w_ifid_valid), 32'(m_ifid_v));
      cmp("wrap_ifid_inst", cyc, w_ifid_inst, m_ifid_inst);
      if (m_ifid_v) cmp("wrap_ifid_pc", cyc, w_ifid_pc, m_ifid_pc - 32'd4);
    end
`ifdef IF_PERF_CNT_EN
    cmp("perf_fetch", cyc, perf_fetch, m_fetch);
    cmp("perf_stall", cyc, perf_stall, m_stallc);
    if (cyc <= 13) begin
      cmp("wrap_perf_fetch", cyc, w_perf_fetch, m_fetch);
      cmp("wrap_perf_stall", cyc, w_perf_stall, m_stallc);
    end
`endif
  endtask

  task automatic modelStep();
    logic accept, got, deliver;
    logic [31:0] d_pc;
    if (rst) begin
      m_started = 0; m_pc = 0; m_out = 0; m_out_drop = 0; m_out_pc = 0;
      m_skid = 0; m_skid_pc = 0; m_ifid_v = 0; m_ifid_inst = NOP; m_ifid_pc = 0;
`ifdef IF_PERF_CNT_EN
      m_fetch = 0; m_stallc = 0;
`endif
      return;
    end
    accept  = m_started && !m_out && !m_skid && ready;
    got     = m_out && rsp_valid;
    deliver = 0;
    d_pc    = 0;
`ifdef IF_PERF_CNT_EN
    if (stall && m_ifid_v) m_stallc++;
`endif
    if (redirect_valid) begin
      m_ifid_v = 0; m_ifid_inst = NOP; m_skid = 0;
      if (accept) begin
        m_out = 1; m_out_drop = 1;
      end else if (got) begin
        m_out = 0;
      end else if (m_out) begin
        m_out_drop = 1;
      end
      m_pc = redirect_pc & ~32'd3;
    end else begin
      if (accept) begin
        m_out = 1; m_out_drop = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end else if (got) begin
        m_out = 0;
        if (!m_out_drop) begin
          if (stall) begin
            m_skid = 1; m_skid_pc = m_out_pc;
          end else begin
            deliver = 1; d_pc = m_out_pc;
          end
        end
      end else if (m_skid && !stall) begin
        m_skid = 0; deliver = 1; d_pc = m_skid_pc;
      end
      if (deliver) begin
        m_ifid_v = 1; m_ifid_pc = d_pc; m_ifid_inst = mem_f(d_pc);
`ifdef IF_PERF_CNT_EN
        m_fetch++;
`endif
      end else if (!stall) begin
        m_ifid_v = 0; m_ifid_inst = NOP;
      end
    end
    m_started = 1;
  endtask

  task automatic applyStimulus(input logic d_rst, input logic d_stall, input logic d_redir,
                               input logic [31:0] tgt, input logic d_ready, input int lat);
    rst = d_rst; stall = d_stall; redirect_valid = d_redir; redirect_pc = tgt; ready = d_ready;
    if (d_rst) begin
      mem_busy = 0; rsp_valid = 0; rsp_data = $urandom;
    end else begin
      rsp_valid = mem_busy && (mem_cnt == 0);
      rsp_data  = rsp_valid ? mem_f(mem_addr) : $urandom;
      if (rsp_valid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (req_valid && d_ready) begin
        mem_busy = 1; mem_addr = req_addr; mem_cnt = lat - 1;
        acc_q.push_back(req_addr);
      end
      if (w_req_valid && d_ready) wrap_q.push_back(w_req_addr);
    end
    modelStep();
  endtask

  initial begin
    logic [31:0] exp_acc [9];
    logic [31:0] exp_pc [6];
    exp_acc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h200, 32'h204, 32'h208};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h200, 32'h204};

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n > 0) checkOutput(n);
      if (n == 1) begin
        cmp("reset_req_valid", n, 32'(req_valid), 32'h0);
        cmp("reset_ifid_valid", n, 32'(ifid_valid), 32'h0);
        cmp("reset_ifid_inst", n, ifid_inst, 32'h13);
        cmp("reset_ifid_pc", n, ifid_pc, 32'h0);
      end
      if (n == 10) begin
        cmp("hold_req_valid", n, 32'(req_valid), 32'h0);
        cmp("hold_ifid_pc", n, ifid_pc, 32'h4);
      end
      if (n >= 1 && n <= 25 && ifid_valid) begin
        obs_pc_q.push_back(ifid_pc);
        obs_inst_q.push_back(ifid_inst);
      end
      if (n == 26) begin
        cmp("accept_count", n, 32'(acc_q.size()), 32'd9);
        if (acc_q.size() >= 9)
          for (int i = 0; i < 9; i++) cmp("accept_addr", n, acc_q[i], exp_acc[i]);
        cmp("ifid_count", n, 32'(obs_pc_q.size()), 32'd6);
        if (obs_pc_q.size() >= 6)
          for (int i = 0; i < 6; i++) begin
            cmp("ifid_seq_pc", n, obs_pc_q[i], exp_pc[i]);
            cmp("ifid_seq_inst", n, obs_inst_q[i], exp_pc[i] | 32'h13);
          end
        cmp("wrap_count", n, 32'(wrap_q.size() >= 2), 32'd1);
        if (wrap_q.size() >= 2) begin
          cmp("wrap_first_addr", n, wrap_q[0], 32'hFFFF_FFFC);
          cmp("wrap_second_addr", n, wrap_q[1], 32'h0000_0000);
        end
`ifdef IF_PERF_CNT_EN
        cmp("perf_fetch_directed", n, perf_fetch, 32'd7);
        cmp("perf_stall_directed", n, perf_stall, 32'd0);
`endif
      end
      if (n < 26) begin
        applyStimulus(n < 2, (n >= 8 && n <= 10), (n == 13 || n == 18),
                      (n == 13) ? 32'h103 : 32'h200, 1'b1, (n == 12) ? 3 : 1);
      end else begin
        applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 19) == 0, $urandom,
                      $urandom_range(0, 9) < 6, int'($urandom_range(1, 4)));
      end
    end
    @(negedge clk);
    checkOutput(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
